// File: rtl/hack_seq_ctrl.sv
// hack_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer for the Hack CPU.
// Drives synchronous block-RAM ROM and data RAM, latches the instruction and
// issues one-cycle strobes to the A/D registers, data RAM and PC.
// Optional feature macro: SINGLE_STEP_EN adds a 'step' input that executes
// one instruction per rising edge while run is low.

module hack_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] rom_data,
  input  logic        zr,
  input  logic        ng,
  output logic        rom_en,
  output logic [15:0] ir,
  output logic [5:0]  alu_ctrl,
  output logic        am_sel,
  output logic        ram_rd,
  output logic        a_load,
  output logic        a_sel,
  output logic        d_load,
  output logic        m_write,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [1:0]  state,
  output logic        instr_done
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] ir_q;
  // Cleared by reset and set on the first clock edge afterwards, so the ROM
  // is never enabled in the same cycle that reset is released.
  logic        armed_q;

  logic        stepEdge;
  logic        fetchGo;
  logic        isCInstr;
  logic        jumpTaken;

`ifdef SINGLE_STEP_EN
  logic        step_q;

  // Registered edge detect for the single-step button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign stepEdge = step & ~step_q;
`else
  assign stepEdge = 1'b0;
`endif

  // A fetch is launched only once armed; a step edge outside FETCH is simply
  // not looked at, which discards it.
  assign fetchGo = armed_q & (run | stepEdge);

  // Only 111x patterns are C-instructions; 100/101/110 fall back to A.
  assign isCInstr = &ir_q[15:13];

  // Jump taken when the ALU result's sign class matches any selected bit.
  assign jumpTaken = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~zr & ~ng);

  // Sequencer state and instruction register; WB always returns to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ir_q    <= 16'h0000;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        FETCH: begin
          if (fetchGo) begin
            state_q <= DECODE;
          end
        end
        DECODE: begin
          ir_q    <= rom_data;
          state_q <= EXEC;
        end
        EXEC: begin
          state_q <= WB;
        end
        WB: begin
          state_q <= FETCH;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // Decode fields driving the ALU; they follow ir and are zero for A-instructions.
  always_comb begin
    alu_ctrl = 6'b000000;
    am_sel   = 1'b0;
    if (isCInstr) begin
      alu_ctrl = ir_q[11:6];
      am_sel   = ir_q[12];
    end
  end

  // Per-state strobes; every strobe defaults low so other states issue nothing.
  always_comb begin
    rom_en     = 1'b0;
    ram_rd     = 1'b0;
    a_load     = 1'b0;
    a_sel      = 1'b0;
    d_load     = 1'b0;
    m_write    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      FETCH: begin
        rom_en = fetchGo;
      end
      DECODE: begin
        rom_en = 1'b0;
      end
      EXEC: begin
        ram_rd = isCInstr & ir_q[12];
      end
      WB: begin
        instr_done = 1'b1;
        if (isCInstr) begin
          a_load  = ir_q[5];
          a_sel   = 1'b1;
          d_load  = ir_q[4];
          m_write = ir_q[3];
          pc_load = jumpTaken;
          pc_inc  = ~jumpTaken;
        end else begin
          a_load  = 1'b1;
          a_sel   = 1'b0;
          pc_inc  = 1'b1;
        end
      end
      default: begin
        rom_en = 1'b0;
      end
    endcase
  end

  assign ir    = ir_q;
  assign state = state_q;

endmodule
